// File: rtl/valu_dispatch_pkg.sv
// Shared VALU dispatch definitions: FSM state encoding, NOP control
// word, lane/mask widths and the captured writeback result bundle.
package valu_dispatch_pkg;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_START = 2'd1;
  localparam logic [1:0] ST_WAIT  = 2'd2;
  localparam logic [1:0] ST_WB    = 2'd3;

  localparam logic [31:0] VALU_NOP = 32'h0;

  localparam int LANE_W = 512;
  localparam int MASK_W = 16;

  typedef struct packed {
    logic [LANE_W-1:0] vgpr;
    logic [MASK_W-1:0] sgpr;
    logic [MASK_W-1:0] vcc;
  } valu_res_t;

  function automatic logic is_nop(input logic [31:0] ctl);
    return ctl == VALU_NOP;
  endfunction

endpackage

// File: rtl/valu_dispatch.sv
// Single-issue VALU dispatcher: latch, start, wait for done, write back.
// Optional WAIT watchdog enabled by defining VALU_DISPATCH_TIMEOUT_EN.
module valu_dispatch
  import valu_dispatch_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 64,
  parameter int TAG_W          = 6
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                issue_valid,
  output logic                issue_ready,
  input  logic [31:0]         issue_control,
  input  logic [LANE_W-1:0]   issue_src1,
  input  logic [LANE_W-1:0]   issue_src2,
  input  logic [LANE_W-1:0]   issue_src3,
  input  logic [MASK_W-1:0]   issue_vcc,
  input  logic [MASK_W-1:0]   issue_exec,
  input  logic [TAG_W-1:0]    issue_tag,
  output logic [LANE_W-1:0]   alu_source1_data,
  output logic [LANE_W-1:0]   alu_source2_data,
  output logic [LANE_W-1:0]   alu_source3_data,
  output logic [MASK_W-1:0]   alu_source_vcc_value,
  output logic [MASK_W-1:0]   alu_source_exec_value,
  output logic [31:0]         alu_control,
  output logic                alu_start,
  input  logic [LANE_W-1:0]   alu_vgpr_dest_data,
  input  logic [MASK_W-1:0]   alu_sgpr_dest_data,
  input  logic [MASK_W-1:0]   alu_dest_vcc_value,
  input  logic                valu_done,
  output logic                wb_valid,
  input  logic                wb_ack,
  output logic [LANE_W-1:0]   wb_vgpr_data,
  output logic [MASK_W-1:0]   wb_sgpr_data,
  output logic [MASK_W-1:0]   wb_vcc,
  output logic [MASK_W-1:0]   wb_exec,
  output logic [TAG_W-1:0]    wb_tag,
  output logic                wb_error
);

  logic [1:0]        r_state;
  logic [31:0]       r_control;
  logic [LANE_W-1:0] r_src1;
  logic [LANE_W-1:0] r_src2;
  logic [LANE_W-1:0] r_src3;
  logic [MASK_W-1:0] r_vcc;
  logic [MASK_W-1:0] r_exec;
  logic [TAG_W-1:0]  r_tag;
  valu_res_t         r_wb;

  logic w_in_wait;
  logic w_timeout;

  assign w_in_wait = (r_state == ST_WAIT);

`ifdef VALU_DISPATCH_TIMEOUT_EN
  logic [31:0] r_wait_cnt;
  logic        r_wb_error;

  // Done in the last allowed WAIT cycle still wins over the abort.
  assign w_timeout = w_in_wait && !valu_done &&
                     (r_wait_cnt == 32'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wait_cnt <= '0;
    end else if (r_state == ST_START) begin
      r_wait_cnt <= '0;
    end else if (w_in_wait) begin
      r_wait_cnt <= r_wait_cnt + 32'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wb_error <= 1'b0;
    end else if (r_state == ST_IDLE && issue_valid) begin
      r_wb_error <= 1'b0;
    end else if (w_timeout) begin
      r_wb_error <= 1'b1;
    end
  end

  assign wb_error = r_wb_error;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES > 0);
  assign w_timeout        = 1'b0;
  assign wb_error         = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state   <= ST_IDLE;
      r_control <= '0;
      r_src1    <= '0;
      r_src2    <= '0;
      r_src3    <= '0;
      r_vcc     <= '0;
      r_exec    <= '0;
      r_tag     <= '0;
      r_wb      <= '0;
    end else begin
      unique case (r_state)
        ST_IDLE: begin
          if (issue_valid) begin
            r_control <= issue_control;
            r_src1    <= issue_src1;
            r_src2    <= issue_src2;
            r_src3    <= issue_src3;
            r_vcc     <= issue_vcc;
            r_exec    <= issue_exec;
            r_tag     <= issue_tag;
            r_wb      <= '0;
            r_state   <= is_nop(issue_control) ? ST_WB : ST_START;
          end
        end
        ST_START: r_state <= ST_WAIT;
        ST_WAIT: begin
          if (valu_done) begin
            r_wb.vgpr <= alu_vgpr_dest_data;
            r_wb.sgpr <= alu_sgpr_dest_data;
            r_wb.vcc  <= alu_dest_vcc_value;
            r_state   <= ST_WB;
          end else if (w_timeout) begin
            r_wb    <= '0;
            r_state <= ST_WB;
          end
        end
        ST_WB: begin
          if (wb_ack) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign issue_ready = (r_state == ST_IDLE);
  assign alu_start   = (r_state == ST_START);

  assign alu_control = (alu_start || w_in_wait) ? r_control : '0;

  assign alu_source1_data      = r_src1;
  assign alu_source2_data      = r_src2;
  assign alu_source3_data      = r_src3;
  assign alu_source_vcc_value  = r_vcc;
  assign alu_source_exec_value = r_exec;

  assign wb_valid     = (r_state == ST_WB);
  assign wb_vgpr_data = r_wb.vgpr;
  assign wb_sgpr_data = r_wb.sgpr;
  assign wb_vcc       = r_wb.vcc;
  assign wb_exec      = r_exec;
  assign wb_tag       = r_tag;

endmodule

// File: tb/tb_valu_dispatch.sv
// Directed bench for valu_dispatch with a writeback scoreboard and VALU stub.
module tb_valu_dispatch;

  localparam int TW = 6;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic issue_valid = 1'b0;
  logic issue_ready;
  logic [31:0] issue_control = '0;
  logic [511:0] issue_src1 = '0, issue_src2 = '0, issue_src3 = '0;
  logic [15:0] issue_vcc = '0, issue_exec = '0;
  logic [TW-1:0] issue_tag = '0;
  logic [511:0] alu_source1_data, alu_source2_data, alu_source3_data;
  logic [15:0] alu_source_vcc_value, alu_source_exec_value;
  logic [31:0] alu_control;
  logic alu_start;
  logic [511:0] alu_vgpr_dest_data;
  logic [15:0] alu_sgpr_dest_data, alu_dest_vcc_value;
  logic valu_done;
  logic wb_valid;
  logic wb_ack = 1'b0;
  logic [511:0] wb_vgpr_data;
  logic [15:0] wb_sgpr_data, wb_vcc, wb_exec;
  logic [TW-1:0] wb_tag;
  logic wb_error;

  logic auto_done = 1'b0;
  logic man_done = 1'b0;
  bit model_en = 1'b1;

  // Combinational VALU stub; done timing comes from auto_done/man_done.
  assign alu_vgpr_dest_data = ~alu_source1_data ^ alu_source2_data;
  assign alu_sgpr_dest_data = alu_source_vcc_value ^ alu_source_exec_value
                              ^ alu_source3_data[15:0];
  assign alu_dest_vcc_value = alu_source_vcc_value & alu_source_exec_value;
  assign valu_done = auto_done | man_done;

  valu_dispatch #(.TIMEOUT_CYCLES(TO), .TAG_W(TW)) dut (
    .clk(clk), .rst(rst),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_control(issue_control),
    .issue_src1(issue_src1), .issue_src2(issue_src2),
    .issue_src3(issue_src3),
    .issue_vcc(issue_vcc), .issue_exec(issue_exec),
    .issue_tag(issue_tag),
    .alu_source1_data(alu_source1_data),
    .alu_source2_data(alu_source2_data),
    .alu_source3_data(alu_source3_data),
    .alu_source_vcc_value(alu_source_vcc_value),
    .alu_source_exec_value(alu_source_exec_value),
    .alu_control(alu_control), .alu_start(alu_start),
    .alu_vgpr_dest_data(alu_vgpr_dest_data),
    .alu_sgpr_dest_data(alu_sgpr_dest_data),
    .alu_dest_vcc_value(alu_dest_vcc_value),
    .valu_done(valu_done),
    .wb_valid(wb_valid), .wb_ack(wb_ack),
    .wb_vgpr_data(wb_vgpr_data), .wb_sgpr_data(wb_sgpr_data),
    .wb_vcc(wb_vcc), .wb_exec(wb_exec), .wb_tag(wb_tag),
    .wb_error(wb_error)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  int n_start = 0;
  always @(posedge clk) cyc <= cyc + 1;
  always @(negedge clk) if (alu_start) n_start <= n_start + 1;

  int n_pass = 0;
  int n_tot = 0;

  typedef struct {
    logic [511:0] v;
    logic [15:0]  s, c, e;
    logic [TW-1:0] t;
    logic err;
  } wb_t;
  wb_t exp_q[$];

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    n_tot++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic wb_t mk_exp(input logic [31:0] ctl,
      input logic [511:0] a, b, c, input logic [15:0] vcc, ex,
      input logic [TW-1:0] tg, input bit to);
    wb_t r;
    r.e = ex;
    r.t = tg;
    r.err = to && (ctl != 0);
    if (ctl == 0 || to) begin
      r.v = '0; r.s = '0; r.c = '0;
    end else begin
      r.v = ~a ^ b;
      r.s = vcc ^ ex ^ c[15:0];
      r.c = vcc & ex;
    end
    return r;
  endfunction

  // VALU completion model: done 3 cycles after the start cycle.
  initial forever begin
    @(negedge clk);
    if (alu_start && model_en) begin
      repeat (3) @(posedge clk);
      #1 auto_done = 1'b1;
      @(posedge clk);
      #1 auto_done = 1'b0;
    end
  end

  // Scoreboard compare on every cycle with a writeback offered.
  initial forever begin
    @(negedge clk);
    if (!rst && wb_valid) begin
      if (exp_q.size() == 0) begin
        chk("unexpected_wb", wb_valid, 1'b0);
      end else begin
        chk("wb_vgpr", wb_vgpr_data, exp_q[0].v);
        chk("wb_sgpr", wb_sgpr_data, exp_q[0].s);
        chk("wb_vcc", wb_vcc, exp_q[0].c);
        chk("wb_exec", wb_exec, exp_q[0].e);
        chk("wb_tag", wb_tag, exp_q[0].t);
        chk("wb_error", wb_error, exp_q[0].err);
        chk("wb_busy", issue_ready, 1'b0);
        chk("wb_ctrl0", alu_control, 32'h0);
        if (wb_ack) void'(exp_q.pop_front());
      end
    end
    if (!rst && issue_ready) chk("idle_ctrl0", alu_control, 32'h0);
  end

  task automatic do_issue(input logic [31:0] ctl,
      input logic [511:0] a, b, c, input logic [15:0] vcc, ex,
      input logic [TW-1:0] tg, input bit push, input bit to,
      output int t);
    int k = 0;
    @(negedge clk);
    while (!issue_ready && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!issue_ready) chk("issue_wait", issue_ready, 1'b1);
    issue_valid = 1'b1;
    issue_control = ctl;
    issue_src1 = a; issue_src2 = b; issue_src3 = c;
    issue_vcc = vcc; issue_exec = ex; issue_tag = tg;
    if (push) exp_q.push_back(mk_exp(ctl, a, b, c, vcc, ex, tg, to));
    @(posedge clk);
    #1;
    t = cyc;
    issue_valid = 1'b0;
  endtask

  task automatic wait_wb(output int t);
    int k = 0;
    @(negedge clk);
    while (!wb_valid && k < 200) begin
      @(negedge clk);
      k++;
    end
    if (!wb_valid) chk("wb_wait", wb_valid, 1'b1);
    t = cyc;
  endtask

  task automatic ack_wb();
    @(posedge clk);
    #1 wb_ack = 1'b1;
    @(posedge clk);
    #1 wb_ack = 1'b0;
  endtask

  logic [511:0] a5 = {64{8'hA5}};
  logic [511:0] f0 = {64{8'h0F}};
  logic [31:0] vctl[3] = '{32'h5, 32'h9, 32'hFFFF_FFFF};
  logic [15:0] vexe[3] = '{16'h0000, 16'h00FF, 16'h8001};

  initial begin
    int t, tw, s0;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    chk("rst_ready", issue_ready, 1'b1);
    chk("rst_start", alu_start, 1'b0);
    chk("rst_wbv", wb_valid, 1'b0);
    chk("rst_err", wb_error, 1'b0);
    chk("rst_ctrl", alu_control, 32'h0);
    chk("rst_src1", alu_source1_data, 512'h0);
    chk("rst_wbdata", wb_vgpr_data, 512'h0);
    chk("rst_tag", wb_tag, 6'h0);

    // Basic op, done 3 cycles after start.
    s0 = n_start;
    do_issue(32'h1, a5, f0, 512'h00F0, 16'h1234, 16'hFFFF, 6'd5,
             1'b1, 1'b0, t);
    chk("t1_start", alu_start, 1'b1);
    chk("t1_ctrl", alu_control, 32'h1);
    chk("t1_src1", alu_source1_data, a5);
    @(posedge clk);
    #1 chk("t1_start_once", alu_start, 1'b0);
    wait_wb(tw);
    chk("t1_latency", tw - t, 4);
    chk("t1_vgpr_lit", wb_vgpr_data, {64{8'h55}});
    chk("t1_sgpr_lit", wb_sgpr_data, 16'hED3B);
    chk("t1_vcc_lit", wb_vcc, 16'h1234);
    chk("t1_tag_lit", wb_tag, 6'd5);
    ack_wb();
    chk("t1_nstart", n_start - s0, 1);
    @(negedge clk);
    chk("t1_idle", issue_ready, 1'b1);

    // NOP goes straight to writeback.
    s0 = n_start;
    do_issue(32'h0, a5, f0, a5, 16'h7777, 16'hBEEF, 6'd9,
             1'b1, 1'b0, t);
    chk("nop_wbv", wb_valid, 1'b1);
    chk("nop_exec_lit", wb_exec, 16'hBEEF);
    chk("nop_vgpr_lit", wb_vgpr_data, 512'h0);
    ack_wb();
    chk("nop_nstart", n_start - s0, 0);

    // Stray ack while idle.
    wb_ack = 1'b1;
    @(posedge clk);
    #1 wb_ack = 1'b0;
    chk("stray_ack_ready", issue_ready, 1'b1);
    chk("stray_ack_wbv", wb_valid, 1'b0);

    // Back-pressure: ack withheld 10 cycles, extra issue offered.
    do_issue(32'h22, f0, a5, 512'h3C, 16'h00AA, 16'h0F0F, 6'd33,
             1'b1, 1'b0, t);
    wait_wb(tw);
    s0 = n_start;
    @(posedge clk);
    #1;
    issue_valid = 1'b1;
    issue_control = 32'h7;
    issue_src1 = '1;
    issue_tag = 6'd1;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk);
      #1;
      chk("hold_wbv", wb_valid, 1'b1);
      chk("hold_ready", issue_ready, 1'b0);
    end
    issue_valid = 1'b0;
    ack_wb();
    @(negedge clk);
    chk("hold_not_taken", issue_ready, 1'b1);
    chk("hold_nstart", n_start - s0, 0);

    // Directed vectors, including exec == 0.
    for (int i = 0; i < 3; i++) begin
      do_issue(vctl[i], {16{32'(i + 1) * 32'h1111_1111}}, f0,
               {16{32'hC0DE_0000 + 32'(i)}}, 16'h5A5A, vexe[i],
               6'(i + 20), 1'b1, 1'b0, t);
      wait_wb(tw);
      chk("vec_latency", tw - t, 4);
      ack_wb();
    end

    // done outside WAIT is ignored.
    model_en = 1'b0;
    @(posedge clk);
    #1 man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    chk("idle_done_ready", issue_ready, 1'b1);
    chk("idle_done_wbv", wb_valid, 1'b0);
    do_issue(32'h41, a5, a5, f0, 16'h0001, 16'hFFFE, 6'd44,
             1'b1, 1'b0, t);
    chk("sd_start", alu_start, 1'b1);
    man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("sd_no_wb", wb_valid, 1'b0);
    chk("sd_busy", issue_ready, 1'b0);
    man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    chk("sd_wb", wb_valid, 1'b1);
    ack_wb();

    // Reset while waiting drops the instruction.
    do_issue(32'h77, a5, f0, a5, 16'hFFFF, 16'h1234, 6'd63,
             1'b0, 1'b0, t);
    repeat (3) @(posedge clk);
    #1 rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    chk("wrst_ready", issue_ready, 1'b1);
    chk("wrst_start", alu_start, 1'b0);
    chk("wrst_wbv", wb_valid, 1'b0);
    chk("wrst_err", wb_error, 1'b0);
    chk("wrst_ctrl", alu_control, 32'h0);
    chk("wrst_src1", alu_source1_data, 512'h0);
    chk("wrst_exec", alu_source_exec_value, 16'h0);
    chk("wrst_wbexec", wb_exec, 16'h0);
    chk("wrst_wbtag", wb_tag, 6'h0);
    repeat (5) @(posedge clk);
    #1 chk("wrst_quiet", wb_valid, 1'b0);

`ifdef VALU_DISPATCH_TIMEOUT_EN
    do_issue(32'h3, a5, f0, a5, 16'h00FF, 16'hABCD, 6'd17,
             1'b1, 1'b1, t);
    wait_wb(tw);
    chk("to_latency", tw - t, 1 + TO);
    chk("to_err_lit", wb_error, 1'b1);
    ack_wb();
`else
    do_issue(32'h3, a5, f0, a5, 16'h00FF, 16'hABCD, 6'd17,
             1'b1, 1'b0, t);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      chk("hold_wait_wbv", wb_valid, 1'b0);
      chk("hold_wait_busy", issue_ready, 1'b0);
    end
    man_done = 1'b1;
    @(posedge clk);
    #1 man_done = 1'b0;
    chk("late_done_wbv", wb_valid, 1'b1);
    ack_wb();
`endif

    repeat (3) @(posedge clk);
    chk("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_tot);
    $finish;
  end

endmodule
